// File: rtl/ifetch_pkg.sv
// Shared core constants and the fetch buffer entry type.
// Imported by the fetch stage and its buffer.
package ifetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_fetch_fifo.sv
// Two-entry {pc,instr} buffer between the instruction bus and IF/ID.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
   import ifetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t data_i,
   output fetch_entry_t head_o,
   output logic         empty_o,
   output logic         full_o,
   output logic [1:0]   count_o
);

   fetch_entry_t mem_q [2];
   fetch_entry_t mem_d [2];
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   count_q, count_d;

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == 2'd0);
   assign full_o  = (count_q == 2'd2);
   assign count_o = count_q;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop_i) rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         assert (flush_i || !(push_i && full_o && !pop_i));
         assert (flush_i || !(pop_i && empty_o));
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: credit-limited bus requests, in-flight PC
// tracking, redirect discard and a registered two-entry output buffer.
module ifetch
   import ifetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            jump_i,
   input  logic [XLEN-1:0] jump_addr_i,
   input  logic            hold_i,
   output logic            ibus_req_o,
   output logic [XLEN-1:0] ibus_addr_o,
   input  logic            ibus_gnt_i,
   input  logic            ibus_rvalid_i,
   input  logic [XLEN-1:0] ibus_rdata_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o,
   output logic            instr_valid_o
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [1:0]      out_q, out_d;
   logic [1:0]      disc_q, disc_d;
   logic [XLEN-1:0] shq_q [2];
   logic [XLEN-1:0] shq_d [2];

   logic         granted;
   logic         push;
   logic         pop;
   logic         shq_idx;
   logic [2:0]   credit;
   fetch_entry_t head;
   fetch_entry_t entry;
   logic         empty;
   logic         full;
   logic [1:0]   count;

   assign credit      = {1'b0, out_q} + {1'b0, count};
   assign ibus_req_o  = !full && (credit < 3'(FIFO_DEPTH));
   assign ibus_addr_o = pc_q;
   assign granted     = ibus_req_o && ibus_gnt_i;

   assign push        = ibus_rvalid_i && (disc_q == 2'd0) && !jump_i;
   assign pop         = instr_valid_o && !hold_i;
   assign entry.pc    = shq_q[0];
   assign entry.instr = ibus_rdata_i;

   // A grant needs credit, so at most one request is left after a pop.
   assign shq_idx = ibus_rvalid_i ? 1'b0 : out_q[0];

   always_comb begin
      pc_d = pc_q;
      if (jump_i) pc_d = jump_addr_i;
      else if (granted) pc_d = pc_q + 32'd4;

      out_d = out_q + {1'b0, granted} - {1'b0, ibus_rvalid_i};

      shq_d = shq_q;
      if (ibus_rvalid_i) shq_d[0] = shq_q[1];
      if (granted) shq_d[shq_idx] = pc_q;

      disc_d = disc_q;
      if (jump_i) disc_d = out_d;
      else if (ibus_rvalid_i && disc_q != 2'd0) disc_d = disc_q - 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         out_q    <= 2'd0;
         disc_q   <= 2'd0;
         shq_q[0] <= '0;
         shq_q[1] <= '0;
      end else begin
         assert (!(ibus_rvalid_i && out_q == 2'd0));
         pc_q   <= pc_d;
         out_q  <= out_d;
         disc_q <= disc_d;
         shq_q  <= shq_d;
      end
   end

   fetch_fifo u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (jump_i),
      .data_i  (entry),
      .head_o  (head),
      .empty_o (empty),
      .full_o  (full),
      .count_o (count)
   );

   assign instr_valid_o = !empty;
   assign instr_o       = empty ? NOP : head.instr;
   assign pc_o          = empty ? '0 : head.pc;

endmodule

// File: tb/tb_ifetch.sv
// Directed and randomized checks of the fetch stage against a bus
// responder that returns ~addr one or more cycles after each grant.
module tb_ifetch;
   import ifetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        jump_i = 1'b0;
   logic [31:0] jump_addr_i = '0;
   logic        hold_i = 1'b0;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i = 1'b0;
   logic        ibus_rvalid_i = 1'b0;
   logic [31:0] ibus_rdata_i = '0;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        instr_valid_o;

   int n_chk = 0;
   int n_fail = 0;
   bit rv_en = 1'b0;
   logic [31:0] pend[$];
   logic [63:0] cons[$];

   ifetch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .jump_i        (jump_i),
      .jump_addr_i   (jump_addr_i),
      .hold_i        (hold_i),
      .ibus_req_o    (ibus_req_o),
      .ibus_addr_o   (ibus_addr_o),
      .ibus_gnt_i    (ibus_gnt_i),
      .ibus_rvalid_i (ibus_rvalid_i),
      .ibus_rdata_i  (ibus_rdata_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .instr_valid_o (instr_valid_o)
   );

   always #5 clk = ~clk;

   // Bus responder and consumption monitor, both away from posedge.
   always @(negedge clk) begin
      #1;
      if (rst_n && rv_en && pend.size() > 0) begin
         ibus_rvalid_i = 1'b1;
         ibus_rdata_i  = ~pend[0];
      end else begin
         ibus_rvalid_i = 1'b0;
         ibus_rdata_i  = '0;
      end
      #3;
      if (!rst_n) begin
         pend.delete();
      end else begin
         if (ibus_rvalid_i) pend.delete(0);
         if (ibus_req_o && ibus_gnt_i) pend.push_back(ibus_addr_o);
         if (instr_valid_o && !hold_i && !jump_i)
            cons.push_back({pc_o, instr_o});
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      jump_i = 1'b0;
      hold_i = 1'b0;
      ibus_gnt_i = 1'b0;
      rv_en = 1'b0;
      repeat (2) @(negedge clk);
      cons.delete();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (instr_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b want 0", instr_valid_o);
      end
      n_chk++;
      if (instr_o !== NOP) begin
         n_fail++;
         $display("FAIL reset_instr: got %h want %h", instr_o, NOP);
      end
      n_chk++;
      if (pc_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_pc: got %h want 0", pc_o);
      end
      n_chk++;
      if (ibus_addr_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_addr: got %h want 0", ibus_addr_o);
      end
      do_reset();
      #1;
      n_chk++;
      if (ibus_req_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_req: got %b want 1", ibus_req_o);
      end
   endtask

   task automatic test_stream();
      do_reset();
      ibus_gnt_i = 1'b1;
      rv_en = 1'b1;
      @(negedge clk);
      n_chk++;
      if (instr_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_c2_valid: got %b want 0", instr_valid_o);
      end
      @(negedge clk);
      n_chk++;
      if (instr_valid_o !== 1'b1 || pc_o !== 32'h0) begin
         n_fail++;
         $display("FAIL stream_c3: got v=%b pc=%h want v=1 pc=0",
                  instr_valid_o, pc_o);
      end
      repeat (16) @(negedge clk);
      n_chk++;
      if (cons.size() < 8) begin
         n_fail++;
         $display("FAIL stream_count: got %0d want >=8", cons.size());
      end
      for (int k = 0; k < cons.size(); k++) begin
         n_chk++;
         if (cons[k][63:32] !== 32'(4 * k) || cons[k][31:0] !== ~32'(4 * k)) begin
            n_fail++;
            $display("FAIL stream_pc[%0d]: got %h want pc %h", k,
                     cons[k], 32'(4 * k));
         end
      end
   endtask

   task automatic test_hold();
      logic [31:0] p, i;
      do_reset();
      ibus_gnt_i = 1'b1;
      rv_en = 1'b1;
      repeat (8) @(negedge clk);
      hold_i = 1'b1;
      p = pc_o;
      i = instr_o;
      repeat (5) @(negedge clk);
      n_chk++;
      if (ibus_req_o !== 1'b0 || instr_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_full: got req=%b v=%b want req=0 v=1",
                  ibus_req_o, instr_valid_o);
      end
      n_chk++;
      if (pc_o !== p || instr_o !== i) begin
         n_fail++;
         $display("FAIL hold_frozen: got %h/%h want %h/%h",
                  pc_o, instr_o, p, i);
      end
      hold_i = 1'b0;
      repeat (12) @(negedge clk);
      n_chk++;
      if (cons.size() < 10) begin
         n_fail++;
         $display("FAIL hold_count: got %0d want >=10", cons.size());
      end
      for (int k = 0; k < cons.size(); k++) begin
         n_chk++;
         if (cons[k][63:32] !== 32'(4 * k) || cons[k][31:0] !== ~32'(4 * k)) begin
            n_fail++;
            $display("FAIL hold_seq[%0d]: got %h want pc %h", k,
                     cons[k], 32'(4 * k));
         end
      end
   endtask

   task automatic test_jump();
      do_reset();
      ibus_gnt_i = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++;
      if (ibus_req_o !== 1'b0 || ibus_addr_o !== 32'h8) begin
         n_fail++;
         $display("FAIL jump_pre: got req=%b addr=%h want req=0 addr=8",
                  ibus_req_o, ibus_addr_o);
      end
      jump_i = 1'b1;
      jump_addr_i = 32'h100;
      @(negedge clk);
      jump_i = 1'b0;
      rv_en = 1'b1;
      n_chk++;
      if (ibus_addr_o !== 32'h100) begin
         n_fail++;
         $display("FAIL jump_addr: got %h want 100", ibus_addr_o);
      end
      repeat (12) @(negedge clk);
      n_chk++;
      if (cons.size() < 2) begin
         n_fail++;
         $display("FAIL jump_count: got %0d want >=2", cons.size());
      end else begin
         n_chk++;
         if (cons[0] !== {32'h100, ~32'h100} || cons[1] !== {32'h104, ~32'h104}) begin
            n_fail++;
            $display("FAIL jump_first: got %h %h want pc 100 104",
                     cons[0], cons[1]);
         end
      end
   endtask

   task automatic test_jump_same();
      do_reset();
      ibus_gnt_i = 1'b1;
      rv_en = 1'b1;
      @(negedge clk);
      n_chk++;
      if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h4) begin
         n_fail++;
         $display("FAIL jsame_pre: got req=%b addr=%h want req=1 addr=4",
                  ibus_req_o, ibus_addr_o);
      end
      jump_i = 1'b1;
      jump_addr_i = 32'h200;
      @(negedge clk);
      jump_i = 1'b0;
      repeat (12) @(negedge clk);
      n_chk++;
      if (cons.size() < 2) begin
         n_fail++;
         $display("FAIL jsame_count: got %0d want >=2", cons.size());
      end else begin
         n_chk++;
         if (cons[0] !== {32'h200, ~32'h200} || cons[1] !== {32'h204, ~32'h204}) begin
            n_fail++;
            $display("FAIL jsame_first: got %h %h want pc 200 204",
                     cons[0], cons[1]);
         end
      end
   endtask

   task automatic test_gnt_wait();
      do_reset();
      rv_en = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_chk++;
         if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL wait_req[%0d]: got req=%b addr=%h want 1/0",
                     c, ibus_req_o, ibus_addr_o);
         end
         n_chk++;
         if (instr_valid_o !== 1'b0 || instr_o !== NOP) begin
            n_fail++;
            $display("FAIL wait_out[%0d]: got v=%b instr=%h want 0/%h",
                     c, instr_valid_o, instr_o, NOP);
         end
      end
      ibus_gnt_i = 1'b1;
      repeat (10) @(negedge clk);
      n_chk++;
      if (cons.size() < 2 || cons[0][63:32] !== 32'h0 || cons[1][63:32] !== 32'h4) begin
         n_fail++;
         $display("FAIL wait_resume: got n=%0d want pcs 0,4", cons.size());
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc [4];
      exp_pc[0] = 32'hFFFF_FFF8;
      exp_pc[1] = 32'hFFFF_FFFC;
      exp_pc[2] = 32'h0;
      exp_pc[3] = 32'h4;
      do_reset();
      ibus_gnt_i = 1'b1;
      rv_en = 1'b1;
      jump_i = 1'b1;
      jump_addr_i = 32'hFFFF_FFF8;
      @(negedge clk);
      jump_i = 1'b0;
      repeat (14) @(negedge clk);
      n_chk++;
      if (cons.size() < 4) begin
         n_fail++;
         $display("FAIL wrap_count: got %0d want >=4", cons.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (cons[k][63:32] !== exp_pc[k] || cons[k][31:0] !== ~exp_pc[k]) begin
               n_fail++;
               $display("FAIL wrap_pc[%0d]: got %h want pc %h", k,
                        cons[k], exp_pc[k]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      ibus_gnt_i = 1'b1;
      rv_en = 1'b1;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (instr_valid_o !== 1'b0 || instr_o !== NOP || pc_o !== 32'h0) begin
         n_fail++;
         $display("FAIL rmid_out: got v=%b i=%h pc=%h want 0/%h/0",
                  instr_valid_o, instr_o, pc_o, NOP);
      end
      n_chk++;
      if (ibus_addr_o !== 32'h0 || ibus_req_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_bus: got addr=%h req=%b want 0/1",
                  ibus_addr_o, ibus_req_o);
      end
      do_reset();
      ibus_gnt_i = 1'b1;
      rv_en = 1'b1;
      repeat (8) @(negedge clk);
      n_chk++;
      if (cons.size() < 2 || cons[0][63:32] !== 32'h0 || cons[1][63:32] !== 32'h4) begin
         n_fail++;
         $display("FAIL rmid_restart: got n=%0d want pcs 0,4", cons.size());
      end
   endtask

   task automatic test_soak();
      logic [31:0] exp_pc;
      int used;
      exp_pc = 32'h0;
      used = 0;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         ibus_gnt_i = ($urandom_range(0, 3) != 0);
         rv_en = ($urandom_range(0, 3) != 0);
         hold_i = ($urandom_range(0, 3) == 0);
         jump_i = ($urandom_range(0, 24) == 0);
         jump_addr_i = $urandom & 32'h0000_0FFC;
         if (jump_i) begin
            exp_pc = jump_addr_i;
         end else if (instr_valid_o && !hold_i) begin
            used++;
            n_chk++;
            if (pc_o !== exp_pc || instr_o !== ~exp_pc) begin
               n_fail++;
               $display("FAIL soak[%0d]: got pc=%h i=%h want pc=%h",
                        c, pc_o, instr_o, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
         end
      end
      jump_i = 1'b0;
      hold_i = 1'b0;
      n_chk++;
      if (used < 50) begin
         n_fail++;
         $display("FAIL soak_progress: got %0d want >=50", used);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_hold();
      test_jump();
      test_jump_same();
      test_gnt_wait();
      test_wrap();
      test_reset_mid();
      test_soak();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
